// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, LFSR constants and index widths for the keypad emulator
package keypad_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE} state_e;
   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
   localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 8'hA5;
   localparam int IDX_W = 2;
   function automatic logic [LFSR_W-1:0] lfsr_step(logic [LFSR_W-1:0] q);
      return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
   endfunction
   function automatic logic [15:0] hold_eff(logic [15:0] h);
      return (h == '0) ? 16'd1 : h;
   endfunction
endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: Fibonacci LFSR that supplies the pseudo-random contact bounce pattern
module bounce_lfsr import keypad_pkg::*; #(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   output logic [LFSR_W-1:0] state_o
);
   logic [LFSR_W-1:0] state_q;
   // Advance one step per enabled cycle, hold otherwise
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= SEED;
      else if (en_i) state_q <= lfsr_step(state_q);
   end
   assign state_o = state_q;
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates one matrix-keypad key with bounce, hold and release phases
module keypad_emulator import keypad_pkg::*; #(
   parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
   input  logic             int_osc,
   input  logic             reset,
   input  logic [3:0]       cols,
   output logic [3:0]       rows,
   input  logic             press_req,
   input  logic [IDX_W-1:0] key_row,
   input  logic [IDX_W-1:0] key_col,
   input  logic [15:0]      hold_cycles,
   input  logic [7:0]       bounce_cycles,
   output logic             busy,
   output logic             done
);
   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d, hold_q, hold_d;
   logic [7:0]        bnc_q, bnc_d;
   logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
   logic              contact_q, contact_d, done_q, done_d, lfsr_en;
   logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;

   bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_i  (int_osc),
      .rst_ni (reset),
      .en_i   (lfsr_en),
      .state_o(lfsr_q)
   );

   assign lfsr_en  = (state_q == PRESS_BOUNCE) || (state_q == RELEASE_BOUNCE);
   assign lfsr_nxt = lfsr_en ? lfsr_step(lfsr_q) : lfsr_q;

   // Sequence FSM: one shared down-counter times every phase, exiting at 1
   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == IDLE) ? cnt_q : cnt_q - 16'd1;
      hold_d  = hold_q;
      bnc_d   = bnc_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         IDLE: if (press_req) begin
            row_d   = key_row;
            col_d   = key_col;
            hold_d  = hold_cycles;
            bnc_d   = bounce_cycles;
            state_d = (bounce_cycles == '0) ? HELD : PRESS_BOUNCE;
            cnt_d   = (bounce_cycles == '0) ? hold_eff(hold_cycles) : {8'd0, bounce_cycles};
         end
         PRESS_BOUNCE: if (cnt_q == 16'd1) begin
            state_d = HELD;
            cnt_d   = hold_eff(hold_q);
         end
         HELD: if (cnt_q == 16'd1) begin
            state_d = (bnc_q == '0) ? IDLE : RELEASE_BOUNCE;
            cnt_d   = {8'd0, bnc_q};
         end
         RELEASE_BOUNCE: if (cnt_q == 16'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      contact_d = (state_d == HELD) ||
                  (((state_d == PRESS_BOUNCE) || (state_d == RELEASE_BOUNCE)) && lfsr_nxt[0]);
      done_d    = (state_q != IDLE) && (state_d == IDLE);
   end

   // State, timing, captured key and registered contact
   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         bnc_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         contact_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         bnc_q     <= bnc_d;
         row_q     <= row_d;
         col_q     <= col_d;
         contact_q <= contact_d;
         done_q    <= done_d;
      end
   end

   assign rows = ~({3'b000, contact_q & ~cols[col_q]} << row_q);
   assign busy = (state_q != IDLE);
   assign done = done_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: scoreboard-driven directed bench for keypad_emulator
module tb_keypad_emulator;
   logic        int_osc = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  cols = 4'hF;
   logic [3:0]  rows;
   logic        press_req = 1'b0;
   logic [1:0]  key_row = '0, key_col = '0;
   logic [15:0] hold_cycles = '0;
   logic [7:0]  bounce_cycles = '0;
   logic        busy, done;
   int          checks = 0, failures = 0;

   typedef struct packed {logic c; logic b; logic d;} exp_t;
   exp_t        sb[$];
   logic [7:0]  m_lfsr = 8'hA5;
   int          m_r = 0, m_c = 0;

   always #5 int_osc = ~int_osc;

   keypad_emulator #(.LFSR_SEED(8'hA5)) dut (
      .int_osc      (int_osc),
      .reset        (reset),
      .cols         (cols),
      .rows         (rows),
      .press_req    (press_req),
      .key_row      (key_row),
      .key_col      (key_col),
      .hold_cycles  (hold_cycles),
      .bounce_cycles(bounce_cycles),
      .busy         (busy),
      .done         (done)
   );

   function automatic logic [7:0] step(logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   function automatic logic [3:0] exp_rows(logic con, logic [3:0] cv);
      logic [3:0] e = 4'hF;
      if (con && !cv[m_c]) e[m_r] = 1'b0;
      return e;
   endfunction

   task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic press(int r, int c, int h, int b, bit cyc_cols, logic [3:0] cc, bit meddle, int abort_at);
      int n = 0;
      int busy_n = 0;
      exp_t e;
      logic [3:0] cv;
      @(posedge int_osc); #1;
      key_row = 2'(r);
      key_col = 2'(c);
      hold_cycles = 16'(h);
      bounce_cycles = 8'(b);
      press_req = 1'b1;
      cols = cyc_cols ? 4'b1110 : cc;
      @(negedge int_osc);
      chk("pre_busy", 16'(busy), 16'd0);
      chk("pre_rows", 16'(rows), 16'hF);
      m_r = r;
      m_c = c;
      for (int k = 0; k < b; k++) begin
         sb.push_back(exp_t'{c: m_lfsr[0], b: 1'b1, d: 1'b0});
         m_lfsr = step(m_lfsr);
      end
      for (int k = 0; k < ((h == 0) ? 1 : h); k++) sb.push_back(exp_t'{c: 1'b1, b: 1'b1, d: 1'b0});
      for (int k = 0; k < b; k++) begin
         sb.push_back(exp_t'{c: m_lfsr[0], b: 1'b1, d: 1'b0});
         m_lfsr = step(m_lfsr);
      end
      sb.push_back(exp_t'{c: 1'b0, b: 1'b0, d: 1'b1});
      sb.push_back(exp_t'{c: 1'b0, b: 1'b0, d: 1'b0});
      while (sb.size() > 0) begin
         n++;
         @(posedge int_osc); #1;
         press_req = meddle && (n == b + 2 || n == b + 3);
         if (press_req) begin
            key_row = 2'($urandom);
            key_col = 2'($urandom);
            hold_cycles = 16'($urandom);
            bounce_cycles = 8'($urandom);
         end
         cv = cyc_cols ? ~(4'b0001 << (n % 4)) : cc;
         cols = cv;
         @(negedge int_osc);
         e = sb.pop_front();
         chk($sformatf("rows[%0d]", n), 16'(rows), 16'(exp_rows(e.c, cv)));
         chk($sformatf("busy[%0d]", n), 16'(busy), 16'(e.b));
         chk($sformatf("done[%0d]", n), 16'(done), 16'(e.d));
         busy_n += int'(busy);
         if (n == abort_at) begin
            #2 reset = 1'b0;
            #1;
            chk("abort_rows", 16'(rows), 16'hF);
            chk("abort_busy", 16'(busy), 16'd0);
            chk("abort_done", 16'(done), 16'd0);
            repeat (2) begin
               @(negedge int_osc);
               chk("abort_hold_done", 16'(done), 16'd0);
               chk("abort_hold_busy", 16'(busy), 16'd0);
            end
            reset = 1'b1;
            m_lfsr = 8'hA5;
            sb.delete();
         end
      end
      press_req = 1'b0;
      if (abort_at == 0) chk("busy_cycles", 16'(busy_n), 16'(2 * b + ((h == 0) ? 1 : h)));
      @(negedge int_osc);
      chk("post_done", 16'(done), 16'd0);
   endtask

   initial begin
      #1;
      chk("reset_rows", 16'(rows), 16'hF);
      chk("reset_busy", 16'(busy), 16'd0);
      chk("reset_done", 16'(done), 16'd0);
      repeat (2) @(negedge int_osc);
      chk("reset_done_clk", 16'(done), 16'd0);
      reset = 1'b1;
      press(1, 0, 10, 0, 1'b0, 4'b1110, 1'b0, 0);
      press(1, 0, 10, 0, 1'b0, 4'b1011, 1'b0, 0);
      press(2, 2, 20, 8, 1'b1, 4'hF, 1'b0, 0);
      press(3, 1, 5, 2, 1'b0, 4'b1101, 1'b1, 0);
      press(0, 3, 0, 0, 1'b0, 4'b0111, 1'b0, 0);
      press(1, 0, 10, 3, 1'b0, 4'b1110, 1'b0, 7);
      press(1, 0, 3, 4, 1'b0, 4'b1110, 1'b0, 0);
      press(2, 1, 0, 1, 1'b0, 4'b1101, 1'b0, 0);
      press(0, 0, 2, 0, 1'b0, 4'b1111, 1'b0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
